// File: rtl/mem_wb_stage.sv
// MEM->WB stage register with valid/ready handshake, flush, bubble gating and stall counter.
// Define MEM_WB_SKID_EN to add a one-entry skid buffer and a registered ready_o.
module mem_wb_stage #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [RA_W-1:0]   rd_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [RA_W-1:0]   rd_o,
  output logic [15:0]       stall_cnt_o
);

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              vld_p1;
  logic [PC_W-1:0]   pc_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [DATA_W-1:0] alu_p1;
  logic [DATA_W-1:0] rdData_p1;
  logic [RA_W-1:0]   rd_p1;
  logic [15:0]       stallCnt;
  logic              outFree;

  assign outFree = ~vld_p1 | ready_i;

`ifdef MEM_WB_SKID_EN
  logic              skVld;
  logic [PC_W-1:0]   skPc;
  logic [CTRL_W-1:0] skCtrl;
  logic [DATA_W-1:0] skAlu;
  logic [DATA_W-1:0] skRdData;
  logic [RA_W-1:0]   skRd;
  logic              inXfer;

  // skVld is a flop, so ready_o carries no combinational path from ready_i
  assign ready_o = ~skVld;
  assign inXfer  = valid_i & ~skVld;

  // ---- stage p1: OUT register and skid occupancy ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= '0;
      pc_p1     <= '0;
      alu_p1    <= '0;
      rdData_p1 <= '0;
      rd_p1     <= '0;
      skVld     <= 1'b0;
    end else if (flush_i) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      skVld   <= 1'b0;
    end else if (outFree) begin
      if (skVld) begin
        vld_p1    <= 1'b1;
        pc_p1     <= skPc;
        ctrl_p1   <= skCtrl;
        alu_p1    <= skAlu;
        rdData_p1 <= skRdData;
        rd_p1     <= skRd;
        skVld     <= 1'b0;
      end else if (inXfer) begin
        vld_p1    <= 1'b1;
        pc_p1     <= pc_i;
        ctrl_p1   <= ctrl_i;
        alu_p1    <= alu_i;
        rdData_p1 <= rd_data_i;
        rd_p1     <= rd_i;
      end else begin
        vld_p1  <= 1'b0;
        ctrl_p1 <= '0;
      end
    end else if (inXfer) begin
      skVld <= 1'b1;
    end
  end

  // Skid payload is only meaningful while skVld is set.
  always_ff @(posedge clk) begin
    if (!outFree && inXfer) begin
      skPc     <= pc_i;
      skCtrl   <= ctrl_i;
      skAlu    <= alu_i;
      skRdData <= rd_data_i;
      skRd     <= rd_i;
    end
  end
`else
  assign ready_o = outFree;

  // ---- stage p1: OUT register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= '0;
      pc_p1     <= '0;
      alu_p1    <= '0;
      rdData_p1 <= '0;
      rd_p1     <= '0;
    end else if (flush_i) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (outFree) begin
      if (valid_i) begin
        vld_p1    <= 1'b1;
        pc_p1     <= pc_i;
        ctrl_p1   <= ctrl_i;
        alu_p1    <= alu_i;
        rdData_p1 <= rd_data_i;
        rd_p1     <= rd_i;
      end else begin
        vld_p1  <= 1'b0;
        ctrl_p1 <= '0;
      end
    end
  end
`endif

  // Stall count survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
    end else if (vld_p1 && !ready_i) begin
      stallCnt <= satInc(stallCnt);
    end
  end

  assign valid_o     = vld_p1;
  assign pc_o        = pc_p1;
  assign ctrl_o      = ctrl_p1;
  assign alu_o       = alu_p1;
  assign rd_data_o   = rdData_p1;
  assign rd_o        = rd_p1;
  assign stall_cnt_o = stallCnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a queue of accepted entries models the stage contents.
module tb_mem_wb_stage;
  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int CTRL_W = 2;
`ifdef MEM_WB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [PC_W-1:0]   pc_i, pc_o;
  logic [CTRL_W-1:0] ctrl_i, ctrl_o;
  logic [DATA_W-1:0] alu_i, alu_o, rd_data_i, rd_data_o;
  logic [RA_W-1:0]   rd_i, rd_o;
  logic [15:0]       stall_cnt_o;

  mem_wb_stage #(.PC_W(PC_W), .DATA_W(DATA_W), .RA_W(RA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
    .ctrl_i(ctrl_i), .alu_i(alu_i), .rd_data_i(rd_data_i), .rd_i(rd_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o),
    .ctrl_o(ctrl_o), .alu_o(alu_o), .rd_data_o(rd_data_o), .rd_o(rd_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] rdd;
    logic [4:0]  rd;
  } ent_t;

  ent_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   expCnt = 0;
  bit   monEn  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_ctrl"}, 64'(ctrl_o), 64'd0);
    chk({tag, "_pc"}, 64'(pc_o), 64'd0);
    chk({tag, "_alu"}, 64'(alu_o), 64'd0);
    chk({tag, "_rddata"}, 64'(rd_data_o), 64'd0);
    chk({tag, "_rd"}, 64'(rd_o), 64'd0);
    chk({tag, "_stallcnt"}, 64'(stall_cnt_o), 64'd0);
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
  endtask

  // One cycle of stimulus: drive at negedge, record acceptance just before the rising edge.
  task automatic cyc(input bit v, input logic [31:0] pc, input logic [1:0] ctrl,
                     input bit rdy, input bit fl, output bit acc);
    ent_t e;
    @(negedge clk);
    e.pc   = pc;
    e.ctrl = ctrl;
    e.alu  = $urandom;
    e.rdd  = $urandom;
    e.rd   = 5'($urandom);
    valid_i   = v;
    pc_i      = e.pc;
    ctrl_i    = e.ctrl;
    alu_i     = e.alu;
    rd_data_i = e.rdd;
    rd_i      = e.rd;
    ready_i   = rdy;
    flush_i   = fl;
    #4;
    acc = v && ready_o && !fl;
    if (fl) q.delete();
    else if (acc) q.push_back(e);
  endtask

  // Monitor: compares what the stage presents against the head of the model queue.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (monEn) begin
        ent_t h;
        int   sz;
        sz = q.size();
        chk("ready_o", 64'(ready_o), SKID ? 64'(sz < 2) : 64'(sz == 0 || ready_i));
        chk("valid_o", 64'(valid_o), 64'(sz > 0));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(expCnt));
        chk("squashed_seen", 64'(valid_o && pc_o == 32'h300), 64'd0);
        if (sz > 0) begin
          h = q[0];
          chk("pc_o", 64'(pc_o), 64'(h.pc));
          chk("ctrl_o", 64'(ctrl_o), 64'(h.ctrl));
          chk("alu_o", 64'(alu_o), 64'(h.alu));
          chk("rd_data_o", 64'(rd_data_o), 64'(h.rdd));
          chk("rd_o", 64'(rd_o), 64'(h.rd));
        end else begin
          chk("bubble_ctrl", 64'(ctrl_o), 64'd0);
        end
        if (sz > 0 && !ready_i && expCnt < 65535) expCnt++;
        if (sz > 0 && ready_i) void'(q.pop_front());
      end
    end
  end

  initial begin
    bit a;
    bit got;
    rst = 1'b0; valid_i = 1'b0; pc_i = '0; ctrl_i = '0; alu_i = '0;
    rd_data_i = '0; rd_i = '0; ready_i = 1'b1; flush_i = 1'b0;
    #1;
    chkReset("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    monEn = 1'b1;

    // streaming with ready_i held high
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + 32'(4 * i), 2'($urandom), 1'b1, 1'b0, a);
    repeat (2) cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, a);
    chk("stream_stall_cnt", 64'(stall_cnt_o), 64'd0);

    // stall for 5 cycles with 0x200 in OUT and 0x204 offered
    cyc(1'b1, 32'h200, 2'b01, 1'b1, 1'b0, a);
    got = 1'b0;
    repeat (5) begin
      cyc(!got, 32'h204, 2'b01, 1'b0, 1'b0, a);
      got |= a;
    end
    chk("stall_skid_accept", 64'(got), 64'(SKID));
    cyc(!got, 32'h204, 2'b01, 1'b1, 1'b0, a);
    chk("stall_cnt_5", 64'(stall_cnt_o), 64'd5);
    repeat (3) cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, a);

    // flush with OUT full and an incoming entry
    cyc(1'b1, 32'h2F0, 2'b10, 1'b0, 1'b0, a);
    cyc(1'b1, 32'h300, 2'b11, 1'b0, 1'b1, a);
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, a);
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_ctrl", 64'(ctrl_o), 64'd0);

    // bubble gating
    cyc(1'b1, 32'h400, 2'b11, 1'b1, 1'b0, a);
    cyc(1'b0, 32'h404, 2'b11, 1'b1, 1'b0, a);
    cyc(1'b0, 32'h408, 2'b11, 1'b1, 1'b0, a);
    chk("bubble_valid", 64'(valid_o), 64'd0);
    chk("bubble_we", 64'(ctrl_o[0]), 64'd0);

    // randomized traffic with backpressure and occasional flush
    repeat (400)
      cyc(1'($urandom_range(0, 1)), 32'($urandom) | 32'h1000, 2'($urandom),
          $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, a);

    // asynchronous reset while holding entries
    cyc(1'b1, 32'h500, 2'b01, 1'b0, 1'b0, a);
    cyc(1'b1, 32'h504, 2'b01, 1'b0, 1'b0, a);
    @(negedge clk);
    monEn = 1'b0;
    valid_i = 1'b0;
    #2 rst = 1'b0;
    #1 chkReset("midrst");
    q.delete();
    expCnt = 0;
    @(negedge clk);
    rst = 1'b1;
    monEn = 1'b1;

    // counter saturation
    cyc(1'b1, 32'h600, 2'b01, 1'b0, 1'b0, a);
    repeat (70000) cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, a);
    chk("stall_sat", 64'(stall_cnt_o), 64'hFFFF);
    repeat (3) cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, a);
    chk("sat_hold", 64'(stall_cnt_o), 64'hFFFF);

    monEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
